// File: rtl/button_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// button_conditioner_pkg
// Shared definitions for the push-button conditioner:
//   - btn_state_e : per-channel long-press / auto-repeat state
//   - cnt_width() : width of a counter that must hold values 0..limit
// ---------------------------------------------------------------------------
package button_conditioner_pkg;

    // Long-press tracking state of one channel
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } btn_state_e;

    // Counter width for a counter that must represent 0..limit.
    // Never narrower than one bit so a zero limit still yields a legal vector.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if
// Bundles the board-side button signals of the conditioner.
//   ena         : tile enable, low freezes all counters and strobes
//   btn_raw     : raw asynchronous button pins
//   btn_level   : debounced pressed level (1 = pressed)
//   btn_press   : one-cycle strobe on accepted press
//   btn_release : one-cycle strobe on accepted release
//   btn_long    : one-cycle strobe at long-press threshold and each repeat
// master = the side that drives pins/enable and consumes events,
// slave  = the conditioner itself.
// ---------------------------------------------------------------------------
interface button_conditioner_if #(
    parameter int N_BUTTONS = 3
) ();

    logic                 ena;
    logic [N_BUTTONS-1:0] btn_raw;
    logic [N_BUTTONS-1:0] btn_level;
    logic [N_BUTTONS-1:0] btn_press;
    logic [N_BUTTONS-1:0] btn_release;
    logic [N_BUTTONS-1:0] btn_long;

    modport master (
        output ena,
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  ena,
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );

endinterface

// File: rtl/button_conditioner_channel.sv
// ---------------------------------------------------------------------------
// button_channel
// One button channel: synchroniser, polarity normalisation, debounce,
// press/release strobes and the long-press / auto-repeat FSM.
// Ports:
//   clk, rst_n      : core clock, asynchronous active-low reset
//   ena_i           : enable; low freezes counters, state and level
//   btn_raw_i       : raw asynchronous pin
//   btn_level_o     : debounced pressed level
//   btn_press_o     : one-cycle accepted-press strobe
//   btn_release_o   : one-cycle accepted-release strobe
//   btn_long_o      : one-cycle long-press / repeat strobe
// ---------------------------------------------------------------------------
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 1000,
    parameter int LONG_PRESS_CYCLES = 1000000,
    parameter int REPEAT_CYCLES     = 0,
    parameter int ACTIVE_LOW        = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena_i,
    input  logic btn_raw_i,
    output logic btn_level_o,
    output logic btn_press_o,
    output logic btn_release_o,
    output logic btn_long_o
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int LW = cnt_width(LONG_PRESS_CYCLES);
    localparam int RW = cnt_width(REPEAT_CYCLES);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_PRESS_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    // Pin level that means "not pressed"; also the synchroniser reset value
    localparam logic INACTIVE = (ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pressed;

    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    btn_state_e    state_q, state_d;

    // The synchroniser free-runs even while disabled, so the debouncer sees
    // the true pin level the moment the tile is re-enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{INACTIVE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
        end
    end

    assign pressed = sync_q[SYNC_STAGES-1] ^ INACTIVE;

    // State register for debounce, strobes and long-press tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q    <= '0;
            lcnt_q    <= '0;
            rcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            state_q   <= IDLE;
        end else begin
            dcnt_q    <= dcnt_d;
            lcnt_q    <= lcnt_d;
            rcnt_q    <= rcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            state_q   <= state_d;
        end
    end

    // Next-state logic. Everything holds while disabled and strobes drop to 0.
    // A level change is accepted after DEBOUNCE_CYCLES consecutive mismatches;
    // an accepted release overrides any long/repeat strobe due in that cycle.
    always_comb begin
        dcnt_d    = dcnt_q;
        lcnt_d    = lcnt_q;
        rcnt_d    = rcnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        state_d   = state_q;

        if (ena_i) begin
            if (pressed == level_q) begin
                dcnt_d = '0;
            end else if (dcnt_q == DEB_LAST) begin
                level_d   = pressed;
                dcnt_d    = '0;
                press_d   = pressed;
                release_d = !pressed;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end

            unique case (state_q)
                IDLE: begin
                    if (press_d) begin
                        state_d = HELD;
                        lcnt_d  = '0;
                    end
                end
                HELD: begin
                    if (release_d) begin
                        state_d = IDLE;
                    end else if (lcnt_q == LONG_LAST) begin
                        long_d  = 1'b1;
                        state_d = LONG;
                        rcnt_d  = '0;
                    end else begin
                        lcnt_d = lcnt_q + LW'(1);
                    end
                end
                LONG: begin
                    if (release_d) begin
                        state_d = IDLE;
                    end else if (REPEAT_CYCLES > 0) begin
                        if (rcnt_q == REP_LAST) begin
                            long_d = 1'b1;
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + RW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign btn_level_o   = level_q;
    assign btn_press_o   = press_q;
    assign btn_release_o = release_q;
    assign btn_long_o    = long_q;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Multi-channel push-button front end: N_BUTTONS independent copies of
// button_channel, no cross-channel logic.
// Ports:
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   bus   : button_conditioner_if slave (ena, btn_raw in; level/strobes out)
// ---------------------------------------------------------------------------
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N_BUTTONS         = 3,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 1000,
    parameter int LONG_PRESS_CYCLES = 1000000,
    parameter int REPEAT_CYCLES     = 0,
    parameter int ACTIVE_LOW        = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_conditioner_if.slave  bus
);

    logic [N_BUTTONS-1:0] level_w;
    logic [N_BUTTONS-1:0] press_w;
    logic [N_BUTTONS-1:0] release_w;
    logic [N_BUTTONS-1:0] long_w;

    // One fully independent conditioner per button
    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        button_channel #(
            .SYNC_STAGES      (SYNC_STAGES),
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .REPEAT_CYCLES    (REPEAT_CYCLES),
            .ACTIVE_LOW       (ACTIVE_LOW)
        ) u_channel (
            .clk          (clk),
            .rst_n        (rst_n),
            .ena_i        (bus.ena),
            .btn_raw_i    (bus.btn_raw[i]),
            .btn_level_o  (level_w[i]),
            .btn_press_o  (press_w[i]),
            .btn_release_o(release_w[i]),
            .btn_long_o   (long_w[i])
        );
    end

    assign bus.btn_level   = level_w;
    assign bus.btn_press   = press_w;
    assign bus.btn_release = release_w;
    assign bus.btn_long    = long_w;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
// Drives two conditioners (active-high and active-low pins) with directed
// vectors and checks every cycle against a behavioural model built from
// run lengths and held-cycle arithmetic, plus hand-computed checkpoints.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int NB    = 3;
    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int LONGC = 10;
    localparam int REP   = 3;

    logic clk;
    logic rst_n;
    logic checkEn;
    int   testsRun;
    int   testsFailed;

    button_conditioner_if #(.N_BUTTONS(NB)) busN ();
    button_conditioner_if #(.N_BUTTONS(NB)) busI ();

    button_conditioner #(
        .N_BUTTONS(NB), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .LONG_PRESS_CYCLES(LONGC), .REPEAT_CYCLES(REP), .ACTIVE_LOW(0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (busN)
    );

    button_conditioner #(
        .N_BUTTONS(NB), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .LONG_PRESS_CYCLES(LONGC), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1)
    ) dutInv (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (busI)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state: index 0 = active-high instance, 1 = active-low
    logic [NB-1:0] rawQ0 [$];
    logic [NB-1:0] rawQ1 [$];
    logic [NB-1:0] expLevel   [2];
    logic [NB-1:0] expPress   [2];
    logic [NB-1:0] expRelease [2];
    logic [NB-1:0] expLong    [2];
    int            runLen     [2][NB];
    int            heldCycles [2][NB];

    // Model: pressed level is the raw pin seen SYNC edges ago; a change is
    // accepted after DEB consecutive enabled mismatching cycles; long fires
    // when the enabled held-cycle count reaches LONGC and then every REP.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rawQ0.delete();
            rawQ1.delete();
            for (int d = 0; d < 2; d++) begin
                expLevel[d] = '0; expPress[d] = '0; expRelease[d] = '0; expLong[d] = '0;
                for (int c = 0; c < NB; c++) begin
                    runLen[d][c] = 0;
                    heldCycles[d][c] = 0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < NB; c++) begin
                    logic pv, was, acceptedPress, acceptedRelease;
                    pv = 1'b0;
                    if (d == 0 && rawQ0.size() >= SYNC) pv = rawQ0[rawQ0.size() - SYNC][c];
                    if (d == 1 && rawQ1.size() >= SYNC) pv = ~rawQ1[rawQ1.size() - SYNC][c];
                    expPress[d][c] = 1'b0;
                    expRelease[d][c] = 1'b0;
                    expLong[d][c] = 1'b0;
                    if (busN.ena) begin
                        was = expLevel[d][c];
                        acceptedPress = 1'b0;
                        acceptedRelease = 1'b0;
                        if (pv == was) begin
                            runLen[d][c] = 0;
                        end else begin
                            runLen[d][c]++;
                            if (runLen[d][c] == DEB) begin
                                runLen[d][c] = 0;
                                expLevel[d][c] = pv;
                                acceptedPress = pv;
                                acceptedRelease = !pv;
                            end
                        end
                        expPress[d][c] = acceptedPress;
                        expRelease[d][c] = acceptedRelease;
                        if (acceptedPress) begin
                            heldCycles[d][c] = 0;
                        end else if (was && !acceptedRelease) begin
                            heldCycles[d][c]++;
                            if (heldCycles[d][c] == LONGC ||
                                (REP > 0 && heldCycles[d][c] > LONGC &&
                                 (heldCycles[d][c] - LONGC) % REP == 0))
                                expLong[d][c] = 1'b1;
                        end
                    end
                end
            end
            rawQ0.push_back(busN.btn_raw);
            rawQ1.push_back(busI.btn_raw);
        end
    end

    task automatic checkOutput(input string name, input logic [NB-1:0] actual,
                               input logic [NB-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(posedge clk) begin
        #1;
        if (checkEn && rst_n) begin
            checkOutput("level",    busN.btn_level,   expLevel[0]);
            checkOutput("press",    busN.btn_press,   expPress[0]);
            checkOutput("release",  busN.btn_release, expRelease[0]);
            checkOutput("long",     busN.btn_long,    expLong[0]);
            checkOutput("inv level",   busI.btn_level,   expLevel[1]);
            checkOutput("inv press",   busI.btn_press,   expPress[1]);
            checkOutput("inv release", busI.btn_release, expRelease[1]);
            checkOutput("inv long",    busI.btn_long,    expLong[1]);
        end
    end

    // Inputs change on the falling edge, then wait the given number of cycles
    task automatic applyStimulus(input logic [NB-1:0] raw, input logic [NB-1:0] rawInv,
                                 input logic en, input int cycles);
        busN.btn_raw = raw;
        busI.btn_raw = rawInv;
        busN.ena = en;
        busI.ena = en;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        checkEn = 1'b0;
        rst_n = 1'b0;
        busN.ena = 1'b1;
        busI.ena = 1'b1;
        busN.btn_raw = 3'b000;
        busI.btn_raw = 3'b111;
        repeat (3) @(negedge clk);
        checkOutput("reset level", busN.btn_level, 3'b000);
        checkOutput("reset press", busN.btn_press, 3'b000);
        checkOutput("reset inv level", busI.btn_level, 3'b000);
        checkEn = 1'b1;
        rst_n = 1'b1;

        // 1: idle after reset
        applyStimulus(3'b000, 3'b111, 1'b1, 20);
        checkOutput("idle level", busN.btn_level, 3'b000);

        // 2: clean press on ch0, accepted at edge 6
        applyStimulus(3'b001, 3'b111, 1'b1, 5);
        checkOutput("pre-press level", busN.btn_level, 3'b000);
        applyStimulus(3'b001, 3'b111, 1'b1, 1);
        checkOutput("press ch0", busN.btn_press, 3'b001);
        checkOutput("model press ch0", expPress[0], 3'b001);
        checkOutput("level ch0", busN.btn_level, 3'b001);
        applyStimulus(3'b001, 3'b111, 1'b1, 1);
        checkOutput("press one cycle", busN.btn_press, 3'b000);
        applyStimulus(3'b000, 3'b111, 1'b1, 10);

        // 3: glitches on ch1; only the final stable run is accepted (edge 16)
        applyStimulus(3'b010, 3'b111, 1'b1, 3);
        applyStimulus(3'b000, 3'b111, 1'b1, 3);
        applyStimulus(3'b010, 3'b111, 1'b1, 3);
        applyStimulus(3'b000, 3'b111, 1'b1, 1);
        applyStimulus(3'b010, 3'b111, 1'b1, 5);
        checkOutput("glitch level", busN.btn_level, 3'b000);
        applyStimulus(3'b010, 3'b111, 1'b1, 1);
        checkOutput("glitch press", busN.btn_press, 3'b010);
        applyStimulus(3'b000, 3'b111, 1'b1, 10);

        // 4: long press and repeat on ch2; release wins over a due repeat
        applyStimulus(3'b100, 3'b111, 1'b1, 6);
        checkOutput("press ch2", busN.btn_press, 3'b100);
        applyStimulus(3'b100, 3'b111, 1'b1, 10);
        checkOutput("long ch2", busN.btn_long, 3'b100);
        checkOutput("model long ch2", expLong[0], 3'b100);
        applyStimulus(3'b100, 3'b111, 1'b1, 3);
        checkOutput("repeat 1", busN.btn_long, 3'b100);
        applyStimulus(3'b100, 3'b111, 1'b1, 3);
        checkOutput("repeat 2", busN.btn_long, 3'b100);
        applyStimulus(3'b000, 3'b111, 1'b1, 6);
        checkOutput("release ch2", busN.btn_release, 3'b100);
        checkOutput("no long at release", busN.btn_long, 3'b000);
        applyStimulus(3'b000, 3'b111, 1'b1, 10);

        // 5: active-low instance, ch0 pin driven low
        applyStimulus(3'b000, 3'b110, 1'b1, 6);
        checkOutput("inv press ch0", busI.btn_press, 3'b001);
        checkOutput("model inv press", expPress[1], 3'b001);
        applyStimulus(3'b000, 3'b111, 1'b1, 10);

        // 6a: reset mid-count with ch2 held and ch0 at two mismatches
        applyStimulus(3'b100, 3'b111, 1'b1, 6);
        applyStimulus(3'b101, 3'b111, 1'b1, 4);
        checkOutput("held before reset", busN.btn_level, 3'b100);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset level", busN.btn_level, 3'b000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(3'b101, 3'b111, 1'b1, 5);
        checkOutput("post-reset no press", busN.btn_press, 3'b000);
        applyStimulus(3'b101, 3'b111, 1'b1, 1);
        checkOutput("post-reset press", busN.btn_press, 3'b101);
        applyStimulus(3'b000, 3'b111, 1'b1, 10);

        // 6b: ena low for 5 cycles mid-count delays acceptance to edge 11
        applyStimulus(3'b010, 3'b111, 1'b1, 3);
        applyStimulus(3'b010, 3'b111, 1'b0, 5);
        applyStimulus(3'b010, 3'b111, 1'b1, 2);
        checkOutput("ena delay no press", busN.btn_press, 3'b000);
        applyStimulus(3'b010, 3'b111, 1'b1, 1);
        checkOutput("ena delay press", busN.btn_press, 3'b010);
        applyStimulus(3'b000, 3'b111, 1'b1, 10);

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
